hvac_zone_ctrl: RTL and testbench
=================================

// Module: hvac_zone_ctrl
// PURPOSE
//  Parametrised successor to the fixed-threshold air-conditioning controller.
//  Drives one zone's heater and cooler from a sampled temperature, using
//  hysteresis thresholds and a minimum-dwell (anti-short-cycle) timer.
//  Adds an enable override and an optional sticky sensor-fault state.
//  Sits between the temperature sensor sampler and the heater/cooler drivers.
// PARAMETERS
//  TEMP_W       5   temperature width in bits; unsigned
//  HEAT_ON      18  heating starts when temp <= HEAT_ON
//  HEAT_OFF     20  heating stops when temp >= HEAT_OFF
//  COOL_ON      22  cooling starts when temp >= COOL_ON
//  COOL_OFF     20  cooling stops when temp <= COOL_OFF
//  MIN_DWELL    4   minimum cycles spent in any state; must be >= 1
//  TEMP_MIN     2   fault low limit (HVAC_FAULT_EN only)
//  TEMP_MAX     30  fault high limit (HVAC_FAULT_EN only)
//  FAULT_CYCLES 3   consecutive out-of-range cycles that trip a fault
// PORTS
//  clk          in   1       system clock, rising edge
//  rst          in   1       synchronous reset, active-high
//  enable       in   1       1 = regulate; 0 = force IDLE
//  temperature  in   TEMP_W  sampled zone temperature, unsigned
//  heating      out  1       heater on
//  cooling      out  1       cooler on
//  state        out  2       00 IDLE, 01 HEAT, 10 COOL, 11 FAULT
//  fault        out  1       sticky sensor fault
// BEHAVIOUR
//  - Legal thresholds: HEAT_ON < HEAT_OFF <= COOL_OFF < COOL_ON. All compares are unsigned, TEMP_W bits.
//  - All outputs are registered. They update on the edge that samples the inputs (1-cycle latency).
//  - Reset: state=IDLE, heating=0, cooling=0, fault=0, dwell_cnt=MIN_DWELL (first edge may transition).
//  - heating=(state==HEAT), cooling=(state==COOL). They are never both 1.
//  - Dwell: dwell_cnt loads 1 on state entry, then increments each cycle, saturating at MIN_DWELL.
//    Normal transitions occur only when dwell_cnt==MIN_DWELL, so each state holds >= MIN_DWELL cycles.
//  - Transitions (priority order):
//    1. FAULT: sticky; leaves only on rst.
//    2. enable=0: go to IDLE immediately (dwell ignored); stay there while enable=0.
//    3. IDLE -> HEAT if temp<=HEAT_ON; else IDLE -> COOL if temp>=COOL_ON.
//    4. HEAT -> IDLE if temp>=HEAT_OFF.
//    5. COOL -> IDLE if temp<=COOL_OFF.
//  - HEAT<->COOL is never direct. The path always passes through IDLE, including its dwell.
//  - Holding in a state, including an enable=0 hold in IDLE, keeps dwell_cnt counting toward saturation.
//  - rst mid-operation overrides everything, including FAULT.
// CONFIGURATION
//  HVAC_FAULT_EN defined:
//  - Out-of-range counter counts consecutive cycles with temp<TEMP_MIN or temp>TEMP_MAX.
//    It clears on any in-range sample.
//  - When the count reaches FAULT_CYCLES: enter FAULT on that edge, ignoring dwell and enable.
//    heating=0, cooling=0, fault=1, until rst.
//  HVAC_FAULT_EN undefined:
//  - No counter and no FAULT state.
//  - fault tied 0; state never reads 11; fault limits unused.
// TESTING (defaults)
//  1. rst=1 for 2 cycles with temp=25 -> heating=0, cooling=0, state=00.
//     Release rst -> cooling=1 and state=10 on the first edge.
//  2. From IDLE: temp=17 -> heating=1.
//     Then temp=19 for 10 cycles -> heating stays 1.
//     Then temp=20 -> heating=0 on the next edge.
//  3. Dwell: temp=17 for 1 cycle, then temp=21 -> heating=1 for exactly 4 cycles, then 0.
//  4. No direct swap: temp=17 until HEAT, then temp=25 -> HEAT 4 cycles, IDLE 4 cycles, then cooling=1.
//  5. In COOL with dwell_cnt=1: enable=0 -> cooling=0, state=00 next edge.
//     Re-enable with temp=25 -> cooling=1 after the IDLE dwell expires.
//  6. HVAC_FAULT_EN: temp=31 for 3 cycles -> fault=1, state=11, outputs 0.
//     Then temp=20 -> still fault. rst -> fault=0.

Source files
------------

// File: rtl/hvac_zone_ctrl.sv
// Single-zone heat/cool controller with hysteresis and minimum-dwell timing.
// Optional sticky sensor-fault state is enabled by defining HVAC_FAULT_EN.
module hvac_zone_ctrl #(
    parameter int TEMP_W       = 5,
    parameter int HEAT_ON      = 18,
    parameter int HEAT_OFF     = 20,
    parameter int COOL_ON      = 22,
    parameter int COOL_OFF     = 20,
    parameter int MIN_DWELL    = 4,
    parameter int TEMP_MIN     = 2,
    parameter int TEMP_MAX     = 30,
    parameter int FAULT_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [TEMP_W-1:0] temperature,
    output logic              heating,
    output logic              cooling,
    output logic [1:0]        state,
    output logic              fault
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        HEAT     = 2'b01,
        COOL     = 2'b10,
        FAULT_ST = 2'b11
    } st_t;

    localparam int DW = $clog2(MIN_DWELL + 1);

    // Elaboration-time guard: also the only consumer of the fault limits when the fault path is compiled out.
    if (MIN_DWELL < 1 || !(HEAT_ON < HEAT_OFF && HEAT_OFF <= COOL_OFF && COOL_OFF < COOL_ON) ||
        TEMP_MIN > TEMP_MAX || FAULT_CYCLES < 1) begin : g_bad_param
        $error("hvac_zone_ctrl: illegal parameter set");
    end

    st_t           cur;
    st_t           nxt;
    logic [DW-1:0] dwell_cnt;
    logic          dwell_done;

    assign dwell_done = (dwell_cnt == DW'(MIN_DWELL));
    assign state      = cur;

`ifdef HVAC_FAULT_EN
    localparam int FW = $clog2(FAULT_CYCLES + 1);

    logic [FW-1:0] oor_cnt;
    logic          oor;
    logic          trip;

    assign oor  = (temperature < TEMP_W'(TEMP_MIN)) || (temperature > TEMP_W'(TEMP_MAX));
    // Trips on the edge that samples the FAULT_CYCLES-th consecutive bad reading.
    assign trip = oor && (oor_cnt >= FW'(FAULT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst)
            oor_cnt <= '0;
        else if (!oor)
            oor_cnt <= '0;
        else if (oor_cnt != FW'(FAULT_CYCLES))
            oor_cnt <= oor_cnt + 1'b1;
    end
`endif

    always_comb begin
        nxt = cur;
        if (!enable) begin
            nxt = IDLE;
        end else if (dwell_done) begin
            case (cur)
                IDLE: begin
                    if (temperature <= TEMP_W'(HEAT_ON))
                        nxt = HEAT;
                    else if (temperature >= TEMP_W'(COOL_ON))
                        nxt = COOL;
                end
                HEAT:    if (temperature >= TEMP_W'(HEAT_OFF)) nxt = IDLE;
                COOL:    if (temperature <= TEMP_W'(COOL_OFF)) nxt = IDLE;
                default: nxt = cur;
            endcase
        end
`ifdef HVAC_FAULT_EN
        if (cur == FAULT_ST || trip)
            nxt = FAULT_ST;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur       <= IDLE;
            dwell_cnt <= DW'(MIN_DWELL);
            heating   <= 1'b0;
            cooling   <= 1'b0;
        end else begin
            cur     <= nxt;
            heating <= (nxt == HEAT);
            cooling <= (nxt == COOL);
            if (nxt != cur)
                dwell_cnt <= DW'(1);
            else if (!dwell_done)
                dwell_cnt <= dwell_cnt + 1'b1;
        end
    end

`ifdef HVAC_FAULT_EN
    always_ff @(posedge clk) begin
        if (rst)
            fault <= 1'b0;
        else
            fault <= (nxt == FAULT_ST);
    end
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_hvac_zone_ctrl.sv
// Directed + randomized bench for hvac_zone_ctrl, checked against a
// cycle-level behavioural model of the zone controller rules.
module tb_hvac_zone_ctrl;

    localparam int MIN_DWELL    = 4;
    localparam int FAULT_CYCLES = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [4:0] temperature;
    logic       heating, cooling, fault;
    logic [1:0] state;

    always #5 clk = ~clk;

    hvac_zone_ctrl dut (
        .clk(clk), .rst(rst), .enable(enable), .temperature(temperature),
        .heating(heating), .cooling(cooling), .state(state), .fault(fault)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Model: mode 0 idle, 1 heat, 2 cool, 3 fault; age = cycles since entering the mode.
    int m_st  = 0;
    int m_age = MIN_DWELL;
    int m_oor = 0;

    task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic model(input logic r, input logic e, input int t);
        int prev;
        if (r) begin
            m_st = 0; m_age = MIN_DWELL; m_oor = 0;
            return;
        end
        prev = m_st;
`ifdef HVAC_FAULT_EN
        m_oor = (t < 2 || t > 30) ? m_oor + 1 : 0;
`endif
        if (m_st == 3) m_st = 3;
        else if (m_oor >= FAULT_CYCLES) m_st = 3;
        else if (!e) m_st = 0;
        else if (m_age >= MIN_DWELL) begin
            if (m_st == 0) m_st = (t <= 18) ? 1 : (t >= 22) ? 2 : 0;
            else if (m_st == 1 && t >= 20) m_st = 0;
            else if (m_st == 2 && t <= 20) m_st = 0;
        end
        m_age = (m_st != prev) ? 1 : m_age + 1;
    endtask

    function automatic logic [4:0] obs();
        return {state, heating, cooling, fault};
    endfunction

    function automatic logic [4:0] expv();
        logic [1:0] s;
        s = m_st[1:0];
        return {s, m_st == 1, m_st == 2, m_st == 3};
    endfunction

    task automatic step(input logic r, input logic e, input int t);
        @(negedge clk);
        rst = r; enable = e; temperature = t[4:0];
        @(posedge clk);
        model(r, e, t);
        #1;
        chk("model", obs(), expv());
    endtask

    initial begin
        int first;
        int hcnt;
        rst = 1'b1; enable = 1'b1; temperature = 5'd25;

        // reset, then immediate cool on release
        step(1, 1, 25); step(1, 1, 25);
        chk("reset_state", obs(), 5'b00000);
        step(0, 1, 25);
        chk("release_cool", obs(), 5'b10010);

        // heat hysteresis
        step(1, 1, 20); step(0, 1, 17);
        chk("heat_on", obs(), 5'b01100);
        for (int i = 0; i < 10; i++) step(0, 1, 19);
        chk("heat_hold_19", obs(), 5'b01100);
        step(0, 1, 20);
        chk("heat_off_20", obs(), 5'b00000);

        // minimum dwell in HEAT
        step(1, 1, 20); step(0, 1, 17);
        hcnt = heating ? 1 : 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 21);
            if (heating) hcnt++;
        end
        chk("heat_dwell_cnt", 5'(hcnt), 5'd4);

        // heat to cool must pass through IDLE dwell
        step(1, 1, 20); step(0, 1, 17);
        first = -1;
        for (int i = 1; i <= 10; i++) begin
            step(0, 1, 25);
            if (i == 4) chk("swap_idle", obs(), 5'b00000);
            if (cooling && first < 0) first = i;
        end
        chk("swap_first_cool", 5'(first), 5'd8);

        // enable override ignores dwell
        step(1, 1, 20); step(0, 1, 25);
        chk("cool_entry", obs(), 5'b10010);
        step(0, 0, 25);
        chk("disable_idle", obs(), 5'b00000);
        for (int i = 0; i < 3; i++) step(0, 1, 25);
        chk("reenable_wait", obs(), 5'b00000);
        step(0, 1, 25);
        chk("reenable_cool", obs(), 5'b10010);

`ifdef HVAC_FAULT_EN
        step(1, 1, 20);
        step(0, 1, 31); step(0, 1, 31);
        chk("fault_not_yet", {3'b000, fault, 1'b0}, 5'b00000);
        step(0, 1, 31);
        chk("fault_trip", obs(), 5'b11001);
        step(0, 1, 20);
        chk("fault_sticky", obs(), 5'b11001);
        step(1, 1, 20);
        chk("fault_rst", obs(), 5'b00000);
`endif

        // randomized run against the model
        step(1, 1, 20);
        for (int i = 0; i < 400; i++) begin
            logic r, e;
            int   t;
            r = ($urandom_range(99) < 2);
            e = ($urandom_range(99) < 90);
            t = ($urandom_range(9) == 0) ? int'($urandom_range(31)) : int'($urandom_range(24, 15));
            step(r, e, t);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
